lsu_arbiter: RTL
================

LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 4: maximum consecutive grants to one master while the other is requesting (range 1..15).
REQ-002 SHALL have ports i_clk (input, 1): the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n (input, 1): reset, synchronous and active-low.
REQ-004 SHALL have, per master m0 (CPU) and m1 (loader/debug): i_mX_req (in, 1), i_mX_addr (in, 32), i_mX_wdata (in, 32), i_mX_strb (in, 4), i_mX_wren (in, 1), o_mX_gnt (out, 1), o_mX_rdata (out, 32), o_mX_rvld (out, 1), o_mX_rerr (out, 1).
REQ-005 SHALL have LSU-side ports o_lsu_addr (out, 32), o_st_data (out, 32), o_st_strb (out, 4), o_lsu_wren (out, 1), i_ld_data (in, 32), i_data_vld (in, 1).

Function
REQ-006 SHALL grant at most one master per cycle; o_mX_gnt is combinational from the requests and the registered arbitration state, and a request is accepted in the cycle where req and gnt are both high.
REQ-007 SHALL drive the LSU-side outputs combinationally from the granted master's addr/wdata/strb/wren; with no grant, all LSU outputs are 0.
REQ-008 SHALL keep o_lsu_wren at 0 whenever there is no grant, so no MMIO or RAM write and no LCD strobe can occur when idle.
REQ-009 SHALL treat a granted request with wren=0 as a read whose response arrives exactly 1 cycle later; it records the owner and a pending flag in registers.
REQ-010 SHALL, in the response cycle, assert o_mX_rvld for the recorded owner only; o_mX_rdata = i_ld_data if i_data_vld=1, else 0 with o_mX_rerr=1 (unmapped address).
REQ-011 SHALL support back-to-back reads, including alternating masters, with one response per cycle and no bubble.
REQ-012 SHALL hold o_mX_rdata at its last value when rvld=0; o_mX_rerr SHALL be 0 outside response cycles.
REQ-013 SHALL keep a 4-bit burst counter of consecutive grants to the last-granted master; the counter resets to 1 on a change of owner and saturates at BURST_MAX.
REQ-014 SHALL, when both masters request and the counter equals BURST_MAX, grant the other master.
REQ-015 SHALL, when only one master requests, grant it regardless of the counter value.
REQ-016 SHALL never grant a master whose req is low; a dropped request loses the grant in the same cycle.
REQ-017 SHALL ignore i_data_vld in cycles with no pending read.

Reset
REQ-018 SHALL, on reset: all gnt/rvld/rerr = 0, o_mX_rdata = 0, pending flag = 0, last owner = m1 (so m0 wins first tie), burst counter = 0.
REQ-019 SHALL discard any in-flight read response at reset; no rvld in the cycle after reset release.

Configuration
REQ-020 SHALL use macro LSU_ARB_ROUND_ROBIN_EN: when defined, ties go to the master not granted last, in addition to the BURST_MAX limit.
REQ-021 SHALL, when LSU_ARB_ROUND_ROBIN_EN is undefined, use fixed priority m0 > m1, limited only by BURST_MAX.

Structure
REQ-022 SHALL place the master-index enum (ARB_M0, ARB_M1) and the default BURST_MAX constant in shared package lsu_arb_pkg.
REQ-023 SHALL be a single module; the grant decision MAY be a sub-module arb_grant2 (2-way grant with burst limit).

Verification
REQ-024 SHALL cover: m0 reads 0x0000_7800 alone -> gnt same cycle, next cycle o_m0_rvld=1, o_m0_rdata=i_io_sw value, rerr=0.
REQ-025 SHALL cover: m1 reads 0x0000_9000 (unmapped) -> next cycle o_m1_rvld=1, rdata=0, o_m1_rerr=1.
REQ-026 SHALL cover: both masters request continuously, fixed priority, BURST_MAX=4 -> grant pattern m0,m0,m0,m0,m1,m0,m0,m0,m0,m1...
REQ-027 SHALL cover: both masters request continuously with LSU_ARB_ROUND_ROBIN_EN -> grants alternate m0,m1,m0,m1 and each rvld goes to the correct owner.
REQ-028 SHALL cover: m1 write 0xA5 with strb=0001 to 0x0000_7000 while idle otherwise -> o_lsu_wren=1 for one cycle only, LEDR[7:0]=0xA5, no rvld.
REQ-029 SHALL cover: reset asserted the cycle after a granted read -> no rvld follows, and m0 wins the first tie after release.

Source files
------------

// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the two-master LSU arbiter.
package lsu_arb_pkg;

    typedef enum logic {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } arb_idx_e;

    localparam int BURST_MAX_DEFAULT = 4;

endpackage

// File: rtl/arb_grant2.sv
// Two-way grant decision with a burst limit; LSU_ARB_ROUND_ROBIN_EN selects
// round-robin tie breaking instead of fixed priority m0 > m1.
module arb_grant2
    import lsu_arb_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    input  logic [3:0] cnt,
    output logic       gnt0,
    output logic       gnt1
);

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    logic pick_m1;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        pick_m1 = 1'b0;
        if (req0 && req1) begin
`ifdef LSU_ARB_ROUND_ROBIN_EN
            // Strict alternation on ties never lets a run exceed one grant,
            // so the burst limit is met implicitly.
            pick_m1 = (last == ARB_M0);
`else
            pick_m1 = (last == ARB_M0) && (cnt == BURST_LIM);
`endif
            gnt0 = ~pick_m1;
            gnt1 = pick_m1;
        end else begin
            gnt0 = req0;
            gnt1 = req1 & ~req0;
        end
    end

endmodule

// File: rtl/lsu_arbiter.sv
// Two-master LSU arbiter (m0 = CPU, m1 = loader/debug) with one-cycle read
// responses; optional round-robin ties via LSU_ARB_ROUND_ROBIN_EN.
module lsu_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_m0_req,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [3:0]  i_m0_strb,
    input  logic        i_m0_wren,
    output logic        o_m0_gnt,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_rvld,
    output logic        o_m0_rerr,
    input  logic        i_m1_req,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [3:0]  i_m1_strb,
    input  logic        i_m1_wren,
    output logic        o_m1_gnt,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_rvld,
    output logic        o_m1_rerr,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_st_data,
    output logic [3:0]  o_st_strb,
    output logic        o_lsu_wren,
    input  logic [31:0] i_ld_data,
    input  logic        i_data_vld
);

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    arb_idx_e    last_q, last_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    arb_idx_e    owner_q, owner_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        gnt0_raw, gnt1_raw;
    logic        any_gnt;
    arb_idx_e    gnt_idx;
    logic [31:0] resp_data;

    arb_grant2 #(.BURST_MAX(BURST_MAX)) u_grant (
        .req0 (i_m0_req),
        .req1 (i_m1_req),
        .last (last_q),
        .cnt  (cnt_q),
        .gnt0 (gnt0_raw),
        .gnt1 (gnt1_raw)
    );

    // Grants and responses are masked while reset is held so nothing reaches
    // the bus or a master before the state registers have been cleared.
    assign o_m0_gnt = gnt0_raw & i_rst_n;
    assign o_m1_gnt = gnt1_raw & i_rst_n;
    assign any_gnt  = o_m0_gnt | o_m1_gnt;
    assign gnt_idx  = o_m1_gnt ? ARB_M1 : ARB_M0;

    always_comb begin
        o_lsu_addr = '0;
        o_st_data  = '0;
        o_st_strb  = '0;
        o_lsu_wren = 1'b0;
        if (o_m0_gnt) begin
            o_lsu_addr = i_m0_addr;
            o_st_data  = i_m0_wdata;
            o_st_strb  = i_m0_strb;
            o_lsu_wren = i_m0_wren;
        end else if (o_m1_gnt) begin
            o_lsu_addr = i_m1_addr;
            o_st_data  = i_m1_wdata;
            o_st_strb  = i_m1_strb;
            o_lsu_wren = i_m1_wren;
        end
    end

    assign o_m0_rvld  = pend_q & (owner_q == ARB_M0) & i_rst_n;
    assign o_m1_rvld  = pend_q & (owner_q == ARB_M1) & i_rst_n;
    assign resp_data  = i_data_vld ? i_ld_data : 32'h0;
    assign o_m0_rdata = o_m0_rvld ? resp_data : rdata0_q;
    assign o_m1_rdata = o_m1_rvld ? resp_data : rdata1_q;
    assign o_m0_rerr  = o_m0_rvld & ~i_data_vld;
    assign o_m1_rerr  = o_m1_rvld & ~i_data_vld;

    always_comb begin
        last_d   = last_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        pend_d   = any_gnt & ~o_lsu_wren;
        rdata0_d = o_m0_rdata;
        rdata1_d = o_m1_rdata;
        if (any_gnt) begin
            last_d  = gnt_idx;
            owner_d = gnt_idx;
            if (gnt_idx != last_q) begin
                cnt_d = 4'd1;
            end else if (cnt_q != BURST_LIM) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_q   <= ARB_M1;
            cnt_q    <= 4'd0;
            pend_q   <= 1'b0;
            owner_q  <= ARB_M0;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            owner_q  <= owner_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

endmodule
